// File: rtl/player_controller_pkg.sv
// player_controller_pkg: shared state encoding and player physics defaults for the dino game.
// Collision and render logic import this so they agree on the player height range.
package player_controller_pkg;
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RUN  = 3'd1,
    DUCK = 3'd2,
    JUMP = 3'd3,
    FALL = 3'd4,
    DEAD = 3'd5
  } state_t;
  localparam int DEF_HEIGHT_W       = 6;
  localparam int DEF_VEL_W          = 5;
  localparam int DEF_JUMP_VEL       = 10;
  localparam int DEF_GRAVITY        = 1;
  localparam int DEF_FAST_FALL_GRAV = 3;
  localparam int DEF_ANIM_TICKS     = 6;
endpackage

// File: rtl/player_controller.sv
// player_controller: turns start/up/down strobes into run/jump/duck/fast-fall/dead player motion.
// Ports: clk, rst_n (async, active-low); game_tick frame strobe; button_start/up/down and crash
// sampled on game_tick; game_frozen, player_y, player_ducking, player_airborne, run_frame
// and jump_pulse (one clk on jump launch) out, all from registered state.
module player_controller
  import player_controller_pkg::*;
#(
  parameter int HEIGHT_W       = DEF_HEIGHT_W,
  parameter int VEL_W          = DEF_VEL_W,
  parameter int JUMP_VEL       = DEF_JUMP_VEL,
  parameter int GRAVITY        = DEF_GRAVITY,
  parameter int FAST_FALL_GRAV = DEF_FAST_FALL_GRAV,
  parameter int ANIM_TICKS     = DEF_ANIM_TICKS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                game_tick,
  input  logic                button_start,
  input  logic                button_up,
  input  logic                button_down,
  input  logic                crash,
  output logic                game_frozen,
  output logic [HEIGHT_W-1:0] player_y,
  output logic                player_ducking,
  output logic                player_airborne,
  output logic                run_frame,
  output logic                jump_pulse
);
  // Common width wide enough to hold y+vel or vel+gravity without overflow.
  localparam int XW = (HEIGHT_W > VEL_W ? HEIGHT_W : VEL_W) + 1;
  localparam int AW = ANIM_TICKS > 1 ? $clog2(ANIM_TICKS) : 1;
  localparam logic [HEIGHT_W-1:0] Y_MAX = '1;
  localparam logic [VEL_W-1:0] VEL_MAX = '1;

  state_t              r_state, w_state_n;
  logic [HEIGHT_W-1:0] r_y, w_y_n;
  logic [VEL_W-1:0]    r_vel, w_vel_n;
  logic [AW-1:0]       r_anim, w_anim_n;
  logic                r_frame, w_frame_n;
  logic                r_jp, w_jp_n;
  logic [XW-1:0]       w_y_sum, w_vel_up_x;
  logic [VEL_W-1:0]    w_vel_dn, w_vel_up;
  logic                w_active, w_anim_wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_y     <= '0;
      r_vel   <= '0;
      r_anim  <= '0;
      r_frame <= 1'b0;
      r_jp    <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_y     <= w_y_n;
      r_vel   <= w_vel_n;
      r_anim  <= w_anim_n;
      r_frame <= w_frame_n;
      r_jp    <= w_jp_n;
    end
  end

  always_comb begin
    w_state_n   = r_state;
    w_y_n       = r_y;
    w_vel_n     = r_vel;
    w_anim_n    = r_anim;
    w_frame_n   = r_frame;
    w_jp_n      = 1'b0;
    w_active    = (r_state == RUN) || (r_state == DUCK) || (r_state == JUMP) || (r_state == FALL);
    w_anim_wrap = r_anim == AW'(ANIM_TICKS - 1);
    // Saturating rise, decay and fall-acceleration terms.
    w_y_sum     = XW'(r_y) + XW'(r_vel);
    w_vel_dn    = r_vel > VEL_W'(GRAVITY) ? r_vel - VEL_W'(GRAVITY) : '0;
    w_vel_up_x  = XW'(r_vel) + XW'(button_down ? FAST_FALL_GRAV : GRAVITY);
    w_vel_up    = w_vel_up_x > XW'(VEL_MAX) ? VEL_MAX : w_vel_up_x[VEL_W-1:0];
    if (game_tick) begin
      if (w_active && crash) begin
        w_state_n = DEAD;
      end else if (!w_active && button_start) begin
        w_state_n = RUN;
        w_y_n     = '0;
        w_vel_n   = '0;
        w_anim_n  = '0;
        w_frame_n = 1'b0;
      end else begin
        case (r_state)
          RUN, DUCK: begin
            w_anim_n  = w_anim_wrap ? '0 : r_anim + AW'(1);
            w_frame_n = w_anim_wrap ? ~r_frame : r_frame;
            w_state_n = button_up ? JUMP : (button_down ? DUCK : RUN);
            w_vel_n   = button_up ? VEL_W'(JUMP_VEL) : r_vel;
            w_jp_n    = button_up;
          end
          JUMP: begin
            // Down aborts the rise: velocity restarts from zero at the current height.
            w_y_n     = button_down ? r_y : (w_y_sum > XW'(Y_MAX) ? Y_MAX : w_y_sum[HEIGHT_W-1:0]);
            w_vel_n   = button_down ? '0 : w_vel_dn;
            w_state_n = (button_down || w_vel_dn == '0) ? FALL : JUMP;
          end
          FALL: begin
            if (XW'(w_vel_up) >= XW'(r_y)) begin
              w_y_n     = '0;
              w_vel_n   = '0;
              w_state_n = button_down ? DUCK : RUN;
            end else begin
              w_y_n   = r_y - HEIGHT_W'(w_vel_up);
              w_vel_n = w_vel_up;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign game_frozen     = (r_state == IDLE) || (r_state == DEAD);
  assign player_y        = r_y;
  assign player_ducking  = r_state == DUCK;
  assign player_airborne = (r_state == JUMP) || (r_state == FALL);
  assign run_frame       = r_frame;
  assign jump_pulse      = r_jp;
endmodule
